intersection_scheduler: RTL and testbench
=========================================

# intersection_scheduler

Two-approach intersection scheduler that shares one internal 5-bit phase timer between the north-south (NS) and east-west (EW) signal heads. It sequences green, yellow and all-red clearance for each approach, with green extension and gap-out driven by car sensors, and serves latched pedestrian requests during clearance. It sits above the single-approach light controllers and drives both light heads and the walk lamp directly.

## Interface
- GREEN_MIN, 5'd6: minimum green cycles per approach.
- GREEN_MAX, 5'd18: maximum green cycles per approach.
- YELLOW_DURATION, 5'd3: yellow cycles.
- ALLRED_DURATION, 5'd2: all-red clearance cycles, used when no walk is served.
- WALK_DURATION, 5'd10: all-red cycles when a walk is served.
- Legal values: every parameter is 1–31, and GREEN_MIN ≤ GREEN_MAX.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  leaves IDLE; sampled only in IDLE.
- car_ns  in  1  car waiting or arriving on NS.
- car_ew  in  1  car waiting or arriving on EW.
- ped_req  in  1  pedestrian button; level or pulse.
- L_ns  out  2  NS head: 00 off, 01 red, 10 yellow, 11 green.
- L_ew  out  2  EW head, same encoding.
- walk  out  1  walk lamp.
- phase  out  3  current state encoding.
- t_count  out  5  remaining cycles minus one in the current state.
- ped_pending  out  1  latched, unserved pedestrian request.

## Operation
- State encodings and head outputs:
  - IDLE = 000: both heads 01.
  - NS_G = 001: L_ns 11, L_ew 01.
  - NS_Y = 010: L_ns 10, L_ew 01.
  - AR1 = 011: both heads 01.
  - EW_G = 100: L_ew 11, L_ns 01.
  - EW_Y = 101: L_ew 10, L_ns 01.
  - AR2 = 110: both heads 01.
  - Unused encoding 111: next state IDLE.
- Phase order: IDLE –start→ NS_G → NS_Y → AR1 → EW_G → EW_Y → AR2 → NS_G, repeating.
- Timer load: on every state transition, t_count loads (duration − 1) of the entered state. Otherwise it decrements while nonzero and holds at 0.
- Durations:
  - Green: GREEN_MAX.
  - Yellow: YELLOW_DURATION.
  - AR: WALK_DURATION if a walk is served, else ALLRED_DURATION.
- Green exit occurs when either condition holds:
  - t_count == 0 (max-out).
  - Gap-out: elapsed ≥ GREEN_MIN, i.e. t_count ≤ GREEN_MAX − GREEN_MIN, and own car = 0 and cross car = 1.
- Yellow and AR exit when t_count == 0.
- Pedestrian latch:
  - ped_pending sets when ped_req = 1 in any state except an AR state with walk = 1.
  - On the cycle a transition into AR1 or AR2 occurs, (ped_pending | ped_req) selects walk service.
  - On that transition, ped_pending clears and walk = 1 for the whole AR state.
- All outputs are registered; no combinational input-to-output path.

## Timing
- Reset values: state IDLE, L_ns = L_ew = 01, walk 0, phase 000, t_count 0, ped_pending 0. Reset asserted mid-phase returns to these values immediately (asynchronously), dropping any pending request.
- start = 1 sampled in IDLE: NS_G entered at the next edge, with t_count = GREEN_MAX − 1. start is ignored in all other states.
- Each state lasts exactly its duration in cycles, measured from entry edge to exit edge. Gap-out shortens green to no fewer than GREEN_MIN cycles.
- Sensors are sampled on the edge that would perform the transition. One cycle of car_ew = 1 with car_ns = 0 at the eligible point is sufficient for gap-out.
- Both cars present, or neither present: green runs to max-out.
- ped_req on the same edge as entry into AR: served in that AR, and ped_pending stays 0.
- ped_req during a walk: ignored.
- ped_req during a non-walk AR: latched for the next AR.

## Configuration
- PED_WALK_EN defined: pedestrian latch and walk service as specified.
- PED_WALK_EN undefined:
  - ped_req is ignored; walk and ped_pending are tied 0.
  - Every AR lasts ALLRED_DURATION.
  - WALK_DURATION is unused.

## Test plan
- Reset, then start pulse with no cars: phase sequence 001 ×18, 010 ×3, 011 ×2, 100 ×18, 101 ×3, 110 ×2, 001; L_ns/L_ew match each state.
- NS_G with car_ns = 0 and car_ew = 1 held: NS_Y entered exactly 6 cycles after NS_G entry. car_ns = 1 and car_ew = 1: NS_Y entered after 18 cycles.
- One-cycle ped_req pulse during EW_G: ped_pending = 1 until AR2 entry; then AR2 lasts 10 cycles with walk = 1; ped_pending = 0; the following AR1 lasts 2 cycles with walk = 0.
- ped_req on the exact NS_Y→AR1 transition edge: AR1 walk = 1 for 10 cycles, and ped_pending never asserts.
- reset asserted low at EW_Y with t_count = 1: outputs go to reset values without waiting for a clock edge; with start low, the block stays in IDLE.
- Build without PED_WALK_EN, pulse ped_req repeatedly: walk = 0 and ped_pending = 0 throughout; every AR lasts 2 cycles.

Source files
------------

// File: rtl/intersection_scheduler.sv
// Two-approach intersection scheduler: one shared phase timer sequencing NS/EW green, yellow and all-red.
// Optional pedestrian walk service during all-red is enabled by defining PED_WALK_EN.
//
// state | meaning
// IDLE  | both heads red, waiting for start
// NS_G  | north-south green, east-west red
// NS_Y  | north-south yellow, east-west red
// AR1   | all-red clearance after NS (walk if served)
// EW_G  | east-west green, north-south red
// EW_Y  | east-west yellow, north-south red
// AR2   | all-red clearance after EW (walk if served)
module intersection_scheduler #(
  parameter logic [4:0] GREEN_MIN       = 5'd6,
  parameter logic [4:0] GREEN_MAX       = 5'd18,
  parameter logic [4:0] YELLOW_DURATION = 5'd3,
  parameter logic [4:0] ALLRED_DURATION = 5'd2,
  parameter logic [4:0] WALK_DURATION   = 5'd10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       car_ns,
  input  logic       car_ew,
  input  logic       ped_req,
  output logic [1:0] L_ns,
  output logic [1:0] L_ew,
  output logic       walk,
  output logic [2:0] phase,
  output logic [4:0] t_count,
  output logic       ped_pending
);

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    NS_G = 3'b001,
    NS_Y = 3'b010,
    AR1  = 3'b011,
    EW_G = 3'b100,
    EW_Y = 3'b101,
    AR2  = 3'b110,
    BAD  = 3'b111
  } state_t;

  localparam logic [1:0] LAMP_RED    = 2'b01;
  localparam logic [1:0] LAMP_YELLOW = 2'b10;
  localparam logic [1:0] LAMP_GREEN  = 2'b11;

  state_t     state, state_nxt;
  logic [4:0] t_nxt;
  logic [4:0] ar_len;
  logic [1:0] l_ns_nxt, l_ew_nxt;
  logic       walk_nxt, pend_nxt;
  logic       changing, enter_ar, gap_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      t_count     <= 5'd0;
      L_ns        <= LAMP_RED;
      L_ew        <= LAMP_RED;
      walk        <= 1'b0;
      ped_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      t_count     <= t_nxt;
      L_ns        <= l_ns_nxt;
      L_ew        <= l_ew_nxt;
      walk        <= walk_nxt;
      ped_pending <= pend_nxt;
    end
  end

  assign phase = state;

  always_comb begin
    state_nxt = state;
    // Gap-out becomes legal once GREEN_MIN cycles of green have elapsed.
    gap_ok    = (t_count <= (GREEN_MAX - GREEN_MIN));
    case (state)
      IDLE: if (start) state_nxt = NS_G;
      NS_G: if (t_count == 5'd0 || (gap_ok && !car_ns && car_ew)) state_nxt = NS_Y;
      NS_Y: if (t_count == 5'd0) state_nxt = AR1;
      AR1:  if (t_count == 5'd0) state_nxt = EW_G;
      EW_G: if (t_count == 5'd0 || (gap_ok && !car_ew && car_ns)) state_nxt = EW_Y;
      EW_Y: if (t_count == 5'd0) state_nxt = AR2;
      AR2:  if (t_count == 5'd0) state_nxt = NS_G;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    changing = (state_nxt != state);
    enter_ar = changing && (state_nxt == AR1 || state_nxt == AR2);
`ifdef PED_WALK_EN
    walk_nxt = walk;
    pend_nxt = ped_pending;
    if (enter_ar) begin
      walk_nxt = ped_pending | ped_req;
      pend_nxt = 1'b0;
    end else begin
      if (changing) walk_nxt = 1'b0;
      // A request during an active walk is already being served.
      if (ped_req && !(walk && (state == AR1 || state == AR2))) pend_nxt = 1'b1;
    end
    ar_len = walk_nxt ? WALK_DURATION : ALLRED_DURATION;
`else
    walk_nxt = 1'b0;
    pend_nxt = 1'b0;
    ar_len   = ALLRED_DURATION;
`endif
  end

`ifndef PED_WALK_EN
  logic ped_unused;
  assign ped_unused = ^{ped_req, WALK_DURATION};
`endif

  always_comb begin
    t_nxt = t_count;
    if (changing) begin
      case (state_nxt)
        NS_G, EW_G: t_nxt = GREEN_MAX - 5'd1;
        NS_Y, EW_Y: t_nxt = YELLOW_DURATION - 5'd1;
        AR1, AR2:   t_nxt = ar_len - 5'd1;
        default:    t_nxt = 5'd0;
      endcase
    end else if (t_count != 5'd0) begin
      t_nxt = t_count - 5'd1;
    end
  end

  always_comb begin
    l_ns_nxt = LAMP_RED;
    l_ew_nxt = LAMP_RED;
    case (state_nxt)
      NS_G: l_ns_nxt = LAMP_GREEN;
      NS_Y: l_ns_nxt = LAMP_YELLOW;
      EW_G: l_ew_nxt = LAMP_GREEN;
      EW_Y: l_ew_nxt = LAMP_YELLOW;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler: elapsed-cycle reference model, per-cycle compare, directed and random stimulus.
module tb_intersection_scheduler;

  localparam int GMIN = 6, GMAX = 18, YEL = 3, ARD = 2, WLK = 10;
`ifdef PED_WALK_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic       clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic       car_ns = 1'b0, car_ew = 1'b0, ped_req = 1'b0;
  logic [1:0] L_ns, L_ew;
  logic       walk, ped_pending;
  logic [2:0] phase;
  logic [4:0] t_count;

  intersection_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .car_ns(car_ns), .car_ew(car_ew),
    .ped_req(ped_req), .L_ns(L_ns), .L_ew(L_ew), .walk(walk), .phase(phase),
    .t_count(t_count), .ped_pending(ped_pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: phase index, cycles elapsed in phase, walk and pending flags.
  int m_ph = 0, m_el = 0;
  bit m_walk = 0, m_pend = 0;

  function automatic int dur_of(input int ph, input bit w);
    case (ph)
      1, 4: return GMAX;
      2, 5: return YEL;
      3, 6: return w ? WLK : ARD;
      default: return 1;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    int nxt;
    bit last, in_walk;
    if (!reset) begin
      m_ph = 0; m_el = 0; m_walk = 0; m_pend = 0;
    end else begin
      nxt  = m_ph;
      last = (m_el == dur_of(m_ph, m_walk) - 1);
      case (m_ph)
        0: if (start) nxt = 1;
        1: if (last || (m_el >= GMIN - 1 && !car_ns && car_ew)) nxt = 2;
        4: if (last || (m_el >= GMIN - 1 && !car_ew && car_ns)) nxt = 5;
        2, 3, 5: if (last) nxt = m_ph + 1;
        6: if (last) nxt = 1;
        default: nxt = 0;
      endcase
      in_walk = (m_ph == 3 || m_ph == 6) && m_walk;
      if (nxt != m_ph && (nxt == 3 || nxt == 6)) begin
        m_walk = PED && (m_pend || ped_req);
        m_pend = 0;
      end else begin
        if (nxt != m_ph) m_walk = 0;
        if (PED && ped_req && !in_walk) m_pend = 1;
      end
      m_el = (nxt != m_ph) ? 0 : m_el + 1;
      m_ph = nxt;
    end
  end

  always @(negedge clk) begin
    int e_ns, e_ew, e_t;
    if (chk_en) begin
      e_ns = 1; e_ew = 1;
      case (m_ph)
        1: e_ns = 3;
        2: e_ns = 2;
        4: e_ew = 3;
        5: e_ew = 2;
        default: ;
      endcase
      e_t = (m_ph == 0) ? 0 : dur_of(m_ph, m_walk) - 1 - m_el;
      chk("phase", phase, m_ph);
      chk("t_count", t_count, e_t);
      chk("L_ns", L_ns, e_ns);
      chk("L_ew", L_ew, e_ew);
      chk("walk", walk, m_walk);
      chk("ped_pending", ped_pending, m_pend);
    end
  end

  // Counts consecutive sampled cycles spent in phase p, starting with the current one.
  task automatic run(input int p, output int n);
    n = 0;
    while (phase == 3'(p) && n < 64) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while (phase != 3'(p) && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("wait_phase", phase, p);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_phase", phase, 0);
    chk("rst_t", t_count, 0);
    chk("rst_L_ns", L_ns, 1);
    chk("rst_L_ew", L_ew, 1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_hold", phase, 0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_phase", phase, 1);
    chk("start_t", t_count, 17);
    chk("ns_g_L_ns", L_ns, 3);
    chk("ns_g_L_ew", L_ew, 1);
    run(1, n); chk("len_ns_g", n, 18);
    run(2, n); chk("len_ns_y", n, 3);
    run(3, n); chk("len_ar1", n, 2);
    run(4, n); chk("len_ew_g", n, 18);
    run(5, n); chk("len_ew_y", n, 3);
    run(6, n); chk("len_ar2", n, 2);
    chk("wrap_phase", phase, 1);

    car_ew = 1'b1;
    run(1, n); chk("gap_out_len", n, 6);
    run(2, n);
    run(3, n);
    car_ns = 1'b1;
    run(4, n); chk("both_cars_ew", n, 18);
    run(5, n);
    run(6, n);
    run(1, n); chk("both_cars_ns", n, 18);
    car_ns = 1'b0; car_ew = 1'b0;

`ifdef PED_WALK_EN
    wait_phase(4);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    chk("ped_latched", ped_pending, 1);
    run(4, n);
    run(5, n);
    chk("ar2_walk", walk, 1);
    chk("ar2_pend_clr", ped_pending, 0);
    run(6, n); chk("walk_ar_len", n, 10);
    run(1, n);
    run(2, n);
    chk("ar1_no_walk", walk, 0);
    run(3, n); chk("plain_ar_len", n, 2);
    n = 0;
    while (!(phase == 3'd2 && t_count == 5'd0) && n < 200) begin
      n++;
      @(negedge clk);
    end
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    chk("edge_ped_phase", phase, 3);
    chk("edge_ped_walk", walk, 1);
    chk("edge_ped_pend", ped_pending, 0);
    run(3, n); chk("edge_ped_len", n, 10);
`endif

    repeat (1500) begin
      @(negedge clk);
      car_ns  = ($urandom_range(0, 3) != 0);
      car_ew  = ($urandom_range(0, 2) == 0);
      ped_req = ($urandom_range(0, 7) == 0);
      start   = $urandom_range(0, 1) == 1;
    end
    @(negedge clk);
    car_ns = 1'b0; car_ew = 1'b0; ped_req = 1'b0; start = 1'b0;

    n = 0;
    while (!(phase == 3'd5 && t_count == 5'd1) && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("reach_ew_y_t1", t_count, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_phase", phase, 0);
    chk("async_t", t_count, 0);
    chk("async_L_ns", L_ns, 1);
    chk("async_L_ew", L_ew, 1);
    chk("async_walk", walk, 0);
    chk("async_pend", ped_pending, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_reset_idle", phase, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
